// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router constants and requester FSM state type
package router_pkg;

  localparam int PORTS    = 16;
  localparam int DEST_W   = 4;
  localparam int DEST_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } req_state_t;

endpackage

// File: rtl/arb_requester_if.sv
// rtl/arb_requester_if.sv - upstream flit, arbiter request/grant and crossbar flit bundle
interface arb_requester_if #(
  parameter int DATA_W = 32,
  parameter int PORTS  = 16
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic [PORTS-1:0]  request;
  logic [PORTS-1:0]  grant;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [3:0]        out_dest;

  // master is the requester itself; slave is the surrounding router fabric
  modport master (
    input  in_valid, in_data, in_last, grant, out_ready,
    output in_ready, request, out_valid, out_data, out_last, out_dest
  );

  modport slave (
    output in_valid, in_data, in_last, grant, out_ready,
    input  in_ready, request, out_valid, out_data, out_last, out_dest
  );

endinterface

// File: rtl/flit_fifo.sv
// rtl/flit_fifo.sv - synchronous flit FIFO; head reads as zero while empty
module flit_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/arb_requester.sv
// rtl/arb_requester.sv - buffers a packet, requests its output arbiter, streams flits; ARB_REQUESTER_WAITCNT_EN adds wait_cycles
module arb_requester #(
  parameter int DATA_W     = 32,
  parameter int PORTS      = router_pkg::PORTS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  arb_requester_if.master   bus
`ifdef ARB_REQUESTER_WAITCNT_EN
  ,
  output logic [15:0]       wait_cycles
`endif
);

  import router_pkg::*;

  req_state_t        state_q;
  logic [DEST_W-1:0] dest_q;
  logic [PORTS-1:0]  request_q;
  logic [DATA_W:0]   head;
  logic [DEST_W-1:0] head_dest;
  logic              fifo_full;
  logic              fifo_empty;
  logic              gnt_sel;
  logic              out_valid;
  logic              pop;

  flit_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (bus.in_valid),
    .data_i  ({bus.in_last, bus.in_data}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // request_q is one-hot at dest_q whenever it is non-zero, so this picks grant[dest] only
  assign gnt_sel   = |(bus.grant & request_q);
  assign head_dest = head[DEST_LSB +: DEST_W];
  assign out_valid = (state_q == XFER) && gnt_sel && !fifo_empty;
  assign pop       = out_valid && bus.out_ready;

  assign bus.in_ready  = !fifo_full;
  assign bus.request   = request_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = head[DATA_W-1:0];
  assign bus.out_last  = head[DATA_W];
  assign bus.out_dest  = 4'(dest_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      dest_q    <= '0;
      request_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q   <= REQ;
            dest_q    <= head_dest;
            request_q <= {{(PORTS-1){1'b0}}, 1'b1} << head_dest;
          end
        end
        REQ: begin
          if (gnt_sel) state_q <= XFER;
        end
        XFER: begin
          if (pop && head[DATA_W]) begin
            state_q   <= IDLE;
            request_q <= '0;
          end
        end
        default: begin
          state_q   <= IDLE;
          request_q <= '0;
        end
      endcase
    end
  end

`ifdef ARB_REQUESTER_WAITCNT_EN
  logic [15:0] wait_q;
  logic [15:0] wait_d;

  always_comb begin
    wait_d = wait_q;
    if (state_q == IDLE && !fifo_empty) begin
      wait_d = '0;
    end else if ((state_q == REQ || (state_q == XFER && !gnt_sel)) && wait_q != 16'hFFFF) begin
      wait_d = wait_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end

  assign wait_cycles = wait_q;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// tb/tb_arb_requester.sv - directed self-checking bench for arb_requester
module tb_arb_requester;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] gnt_en;
  logic [15:0] gnt_other;
  int          vectors     = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  arb_requester_if #(.DATA_W(32), .PORTS(16)) bus ();

  // grant follows request on enabled bits; gnt_other injects grants on foreign ports
  assign bus.grant = (bus.request & gnt_en) | gnt_other;

`ifdef ARB_REQUESTER_WAITCNT_EN
  logic [15:0] wait_cycles;
`endif

  arb_requester #(
    .DATA_W     (32),
    .PORTS      (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ARB_REQUESTER_WAITCNT_EN
    ,
    .wait_cycles (wait_cycles)
`endif
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    gnt_en        = '0;
    gnt_other     = '0;
    tick();
    tick();
    check("rst_request", 64'(bus.request), 64'h0);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_out_last", 64'(bus.out_last), 64'h0);
    check("rst_out_dest", 64'(bus.out_dest), 64'h0);
    check("rst_out_data", 64'(bus.out_data), 64'h0);
    check("rst_in_ready", 64'(bus.in_ready), 64'h1);
    reset = 1'b0;

    // single packet, grant tied to request
    bus.out_ready = 1'b1;
    gnt_en        = 16'hFFFF;
    drive(32'hA000_0005, 1'b0);
    tick();
    drive(32'h1111_1111, 1'b0);
    tick();
    check("p1_request", 64'(bus.request), 64'h0020);
    check("p1_req_no_valid", 64'(bus.out_valid), 64'h0);
    drive(32'h2222_2222, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check("p1_valid_f0", 64'(bus.out_valid), 64'h1);
    check("p1_data_f0", 64'(bus.out_data), 64'hA000_0005);
    check("p1_dest", 64'(bus.out_dest), 64'h5);
    check("p1_last_f0", 64'(bus.out_last), 64'h0);
    tick();
    check("p1_data_f1", 64'(bus.out_data), 64'h1111_1111);
    tick();
    check("p1_data_f2", 64'(bus.out_data), 64'h2222_2222);
    check("p1_last_f2", 64'(bus.out_last), 64'h1);
    tick();
    check("p1_req_drop", 64'(bus.request), 64'h0);
    check("p1_valid_drop", 64'(bus.out_valid), 64'h0);

    // delayed grant with foreign grants asserted, then preemption
    gnt_en    = 16'h0000;
    gnt_other = 16'hFFDF;
    drive(32'hB000_0005, 1'b0);
    tick();
    drive(32'h3333_3333, 1'b0);
    tick();
    drive(32'h4444_4444, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("dly_request", 64'(bus.request), 64'h0020);
    check("dly_out_valid", 64'(bus.out_valid), 64'h0);
`ifdef ARB_REQUESTER_WAITCNT_EN
    check("dly_wait_cycles", 64'(wait_cycles), 64'd10);
`endif
    gnt_other = 16'h0000;
    gnt_en    = 16'hFFFF;
    tick();
    check("pre_data_f0", 64'(bus.out_data), 64'hB000_0005);
    check("pre_valid_f0", 64'(bus.out_valid), 64'h1);
    tick();
    gnt_en = 16'h0000;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("pre_hold_valid", 64'(bus.out_valid), 64'h0);
      check("pre_hold_request", 64'(bus.request), 64'h0020);
      tick();
    end
    gnt_en = 16'hFFFF;
    #1;
    check("pre_resume_valid", 64'(bus.out_valid), 64'h1);
    check("pre_resume_f1", 64'(bus.out_data), 64'h3333_3333);
    tick();
    check("pre_resume_f2", 64'(bus.out_data), 64'h4444_4444);
    check("pre_resume_last", 64'(bus.out_last), 64'h1);
    tick();
    check("pre_req_drop", 64'(bus.request), 64'h0);

    // back-to-back single-flit packets to ports 2 and 9
    drive(32'hC000_0002, 1'b1);
    tick();
    drive(32'hD000_0009, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check("b2b_req_a", 64'(bus.request), 64'h0004);
    tick();
    check("b2b_xfer_a_req", 64'(bus.request), 64'h0004);
    check("b2b_xfer_a_dest", 64'(bus.out_dest), 64'h2);
    tick();
    check("b2b_gap", 64'(bus.request), 64'h0000);
    tick();
    check("b2b_req_b", 64'(bus.request), 64'h0200);
    check("b2b_dest_b", 64'(bus.out_dest), 64'h9);
    tick();
    tick();
    check("b2b_done", 64'(bus.request), 64'h0000);

    // fill the FIFO with the crossbar stalled
    bus.out_ready = 1'b0;
    drive(32'hE000_0003, 1'b0);
    tick();
    drive(32'h5555_5555, 1'b0);
    tick();
    drive(32'h6666_6666, 1'b0);
    tick();
    drive(32'h7777_7777, 1'b1);
    tick();
    check("full_in_ready", 64'(bus.in_ready), 64'h0);
    drive(32'hDEAD_BEEF, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check("full_reject", 64'(bus.in_ready), 64'h0);
    check("full_head", 64'(bus.out_data), 64'hE000_0003);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("full_pop_ready", 64'(bus.in_ready), 64'h1);
    check("full_pop_head", 64'(bus.out_data), 64'h5555_5555);

    // reset in the middle of the transfer
    reset = 1'b1;
    tick();
    check("mid_rst_request", 64'(bus.request), 64'h0);
    check("mid_rst_valid", 64'(bus.out_valid), 64'h0);
    check("mid_rst_data", 64'(bus.out_data), 64'h0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'h1);
    reset = 1'b0;
    tick();
    check("mid_rst_empty", 64'(bus.request), 64'h0);
`ifdef ARB_REQUESTER_WAITCNT_EN
    check("mid_rst_wait", 64'(wait_cycles), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
